sqrt_arbiter: RTL and testbench

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_arb_pkg.sv | 14 +
 rtl/sqrt_arbiter_rr_pick.sv | 33 +++
 rtl/sqrt_arbiter.sv | 130 +++++++++++++
 tb/tb_sqrt_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_arb_pkg.sv
// Shared types and default sizing for the square-root engine arbiter.
package sqrt_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RELEASE
   } state_t;

   localparam int DEF_DATA_W      = 32;
   localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/sqrt_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after last_grant+1 (mod NUM_REQ).
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   grant,
   output logic               any
);

   logic [IDX_W-1:0] cand [NUM_REQ];

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         cand[k] = IDX_W'((int'(last_grant) + k + 1) % NUM_REQ);
      end
   end

   // NOTE: outputs get a default before the loop so every path assigns them and no latch is inferred.
   always_comb begin
      grant = '0;
      any   = 1'b0;
      // Walk from the farthest candidate to the nearest so the nearest one wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            grant = cand[k];
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one square-root engine among NUM_REQ requesters.
// Define SQRT_ARB_TIMEOUT_EN to add a watchdog that ends a stuck transaction with resp_err.
module sqrt_arbiter
   import sqrt_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      resp_err,
   output logic                      busy,
   output logic                      eng_start,
   output logic [DATA_W-1:0]         eng_in,
   input  logic [DATA_W-1:0]         eng_out,
   input  logic                      eng_done,
   input  logic                      eng_available
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("sqrt_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 1");
   end

   state_t           state;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] grant;
   logic [IDX_W-1:0] pick;
   logic             any_req;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (pick),
      .any        (any_req)
   );

`ifdef SQRT_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wdog;
   logic            wdog_hit;
   assign wdog_hit = (wdog == WD_W'(TIMEOUT_CYC - 1));
`else
   assign resp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state      <= IDLE;
         req_ready  <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         eng_start  <= 1'b0;
         eng_in     <= '0;
         busy       <= 1'b0;
         grant      <= '0;
         last_grant <= IDX_W'(NUM_REQ - 1);
`ifdef SQRT_ARB_TIMEOUT_EN
         resp_err   <= 1'b0;
         wdog       <= '0;
`endif
      end else begin
         // NOTE: pulses default low with <= and a later <= to one bit overrides it; the last NBA wins.
         req_ready  <= '0;
         resp_valid <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
         resp_err   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (any_req && eng_available) begin
                  grant           <= pick;
                  req_ready[pick] <= 1'b1;
                  eng_in          <= req_data[pick*DATA_W +: DATA_W];
                  eng_start       <= 1'b1;
                  busy            <= 1'b1;
                  state           <= ISSUE;
`ifdef SQRT_ARB_TIMEOUT_EN
                  wdog            <= '0;
`endif
               end
            end
            ISSUE, WAIT: begin
               if (state == WAIT && eng_done) begin
                  eng_start         <= 1'b0;
                  resp_data         <= eng_out;
                  resp_valid[grant] <= 1'b1;
                  last_grant        <= grant;
                  state             <= RELEASE;
               end
`ifdef SQRT_ARB_TIMEOUT_EN
               else if (wdog_hit) begin
                  eng_start         <= 1'b0;
                  resp_data         <= '0;
                  resp_err          <= 1'b1;
                  resp_valid[grant] <= 1'b1;
                  last_grant        <= grant;
                  state             <= RELEASE;
               end
`endif
               else if (state == ISSUE && !eng_available) begin
                  state <= WAIT;
               end
`ifdef SQRT_ARB_TIMEOUT_EN
               wdog <= wdog + WD_W'(1);
`endif
            end
            RELEASE: begin
               // Hold here until the engine has dropped done and is idle again.
               if (eng_available) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Randomized and directed bench for sqrt_arbiter with a behavioural engine and scoreboard.
// Define SQRT_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_sqrt_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 32;
   localparam int TO_CYC  = 8;

   logic                  clk;
   logic                  rstn;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    resp_valid;
   logic [DW-1:0]         resp_data;
   logic                  resp_err;
   logic                  busy;
   logic                  eng_start;
   logic [DW-1:0]         eng_in;
   logic [DW-1:0]         eng_out;
   logic                  eng_done;
   logic                  eng_available;

   sqrt_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .resp_err      (resp_err),
      .busy          (busy),
      .eng_start     (eng_start),
      .eng_in        (eng_in),
      .eng_out       (eng_out),
      .eng_done      (eng_done),
      .eng_available (eng_available)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] isqrt(input logic [31:0] x);
      longint unsigned r = 0;
      for (int b = 15; b >= 0; b--) begin
         longint unsigned t = r | (64'd1 << b);
         if (t * t <= longint'(x)) r = t;
      end
      return 32'(r);
   endfunction

   function automatic logic [NUM_REQ-1:0] oh(input int i);
      logic [NUM_REQ-1:0] v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Engine model: takes the operand on start, answers after eng_lat cycles, idles once start drops.
   int          eng_lat  = 2;
   bit          eng_hang = 1'b0;
   int          eng_cnt;
   bit          eng_busy;
   logic [31:0] eng_opd;

   always @(posedge clk or posedge rstn) begin
      if (rstn) begin
         eng_available <= 1'b1;
         eng_done      <= 1'b0;
         eng_out       <= '0;
         eng_busy      <= 1'b0;
         eng_cnt       <= 0;
         eng_opd       <= '0;
      end else if (!eng_busy) begin
         eng_done <= 1'b0;
         if (eng_start) begin
            eng_busy      <= 1'b1;
            eng_available <= 1'b0;
            eng_opd       <= eng_in;
            eng_cnt       <= eng_lat;
         end
      end else if (!eng_start) begin
         eng_busy      <= 1'b0;
         eng_done      <= 1'b0;
         eng_available <= 1'b1;
      end else if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
      end else if (!eng_hang) begin
         eng_done <= 1'b1;
         eng_out  <= isqrt(eng_opd);
      end
   end

   // Scoreboard state: what the arbiter should do, derived from the rules, not from the DUT.
   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        err;
      int          t_grant;
   } txn_t;

   txn_t               inflight[$];
   int                 grant_log[$];
   logic [31:0]        resp_log[$];
   int                 served[NUM_REQ];
   int                 served_total = 0;
   int                 rr_last      = NUM_REQ - 1;
   bit [NUM_REQ-1:0]   hold         = '0;
   int                 cyc          = 0;
   logic               prev_start   = 1'b0;

   function automatic int rr_expect();
      for (int k = 1; k <= NUM_REQ; k++) begin
         int i = (rr_last + k) % NUM_REQ;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic raise(input int i, input logic [31:0] val);
      req_valid[i]          = 1'b1;
      req_data[i*DW +: DW]  = val;
   endtask

   task automatic tick();
      txn_t               t;
      int                 exp_i;
      logic [NUM_REQ-1:0] exp_rdy;
      @(negedge clk);
      cyc++;
      if (resp_valid != '0) begin
         if (inflight.size() == 0) begin
            check("resp_orphan", resp_valid, '0);
         end else begin
            t = inflight.pop_front();
            check("resp_valid", resp_valid, oh(t.idx));
            check("resp_data", resp_data, t.data);
            check("resp_err", resp_err, t.err);
            if (t.err) begin
               check("to_latency", cyc - t.t_grant, TO_CYC);
               check("to_start", eng_start, 0);
            end
            served[t.idx]++;
            served_total++;
            resp_log.push_back(resp_data);
         end
      end
      if (req_ready != '0) begin
         exp_i   = rr_expect();
         exp_rdy = '0;
         if (exp_i >= 0) exp_rdy = oh(exp_i);
         check("req_ready", req_ready, exp_rdy);
         check("start_gap", prev_start, 0);
         check("single_flight", inflight.size(), 0);
         if (exp_i >= 0) begin
            t.idx     = exp_i;
            t.err     = eng_hang;
            t.data    = eng_hang ? 32'd0 : isqrt(req_data[exp_i*DW +: DW]);
            t.t_grant = cyc;
            inflight.push_back(t);
            grant_log.push_back(exp_i);
            rr_last = exp_i;
            if (!hold[exp_i]) req_valid[exp_i] = 1'b0;
         end
      end
      prev_start = eng_start;
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 400; n++) begin
         if (req_valid == '0 && inflight.size() == 0 && !busy) break;
         tick();
      end
      check({tag, "_busy"}, busy, 0);
      check({tag, "_pending"}, req_valid, '0);
      check({tag, "_inflight"}, inflight.size(), 0);
   endtask

   task automatic apply_reset();
      rstn      = 1'b1;
      req_valid = '0;
      hold      = '0;
      inflight.delete();
      rr_last   = NUM_REQ - 1;
      tick();
      tick();
      rstn = 1'b0;
      grant_log.delete();
      resp_log.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready, '0);
      check({tag, "_resp_valid"}, resp_valid, '0);
      check({tag, "_resp_data"}, resp_data, '0);
      check({tag, "_resp_err"}, resp_err, 0);
      check({tag, "_eng_start"}, eng_start, 0);
      check({tag, "_eng_in"}, eng_in, '0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
      $fatal(1, "tb_sqrt_arbiter timed out");
   end

   initial begin
      int exp_r[4];
      int base;
      int issued;
      logic [31:0] v;
      exp_r     = '{4, 10, 12, 0};
      req_valid = '0;
      req_data  = '0;
      rstn      = 1'b0;
      #1 rstn   = 1'b1;
      #2 check_reset_outputs("por");
      tick();
      tick();
      rstn = 1'b0;

      // Single requester 0 with 144.
      raise(0, 32'd144);
      drain("t1");
      check("t1_grants", grant_log.size(), 1);
      check("t1_resps", resp_log.size(), 1);
      if (resp_log.size() == 1) check("t1_value", resp_log[0], 12);

      // All four at once from a fresh reset: order 0,1,2,3.
      apply_reset();
      raise(0, 32'd16);
      raise(1, 32'd100);
      raise(2, 32'd144);
      raise(3, 32'd0);
      drain("t2");
      check("t2_count", grant_log.size(), 4);
      if (grant_log.size() == 4 && resp_log.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_grant%0d", i), grant_log[i], i);
            check($sformatf("t2_value%0d", i), resp_log[i], exp_r[i]);
         end
      end

      // Requester 2 held valid: back-to-back transactions.
      base    = served[2];
      hold[2] = 1'b1;
      raise(2, 32'd100);
      for (int n = 0; n < 300 && served[2] - base < 3; n++) tick();
      check("t3_served", served[2] - base, 3);
      hold[2] = 1'b0;
      drain("t3");

      // Reset in the middle of WAIT.
      apply_reset();
      raise(1, 32'd81);
      drain("t4a");
      eng_lat = 20;
      raise(2, 32'd100);
      for (int n = 0; n < 50 && !(busy && eng_start && !eng_available); n++) tick();
      tick();
      check("t4_in_wait", {busy, eng_start, eng_available}, 3'b110);
      #2 rstn = 1'b1;
      #1 check_reset_outputs("t4_rst");
      inflight.delete();
      req_valid = '0;
      rr_last   = NUM_REQ - 1;
      grant_log.delete();
      tick();
      rstn    = 1'b0;
      eng_lat = 2;
      raise(0, 32'd9);
      raise(2, 32'd100);
      drain("t4b");
      check("t4_count", grant_log.size(), 2);
      if (grant_log.size() == 2) check("t4_first", grant_log[0], 0);

      // Randomized traffic against the scoreboard.
      base   = served_total;
      issued = 0;
      for (int n = 0; n < 600; n++) begin
         tick();
         eng_lat = int'($urandom_range(0, 4));
         if (n < 500) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                  case ($urandom_range(0, 3))
                     0:       v = 32'd0;
                     1:       v = 32'hFFFF_FFFF;
                     2:       v = $urandom_range(0, 65535) * $urandom_range(0, 65535);
                     default: v = $urandom;
                  endcase
                  raise(i, v);
                  issued++;
               end
            end
         end
      end
      drain("rand");
      check("rand_served", served_total - base, issued);

`ifdef SQRT_ARB_TIMEOUT_EN
      // Engine never finishes: watchdog ends the transaction.
      apply_reset();
      eng_hang = 1'b1;
      raise(3, 32'd49);
      drain("t5");
      check("t5_resps", resp_log.size(), 1);
      eng_hang = 1'b0;
      raise(0, 32'd25);
      drain("t5b");
      if (resp_log.size() == 2) check("t5_recover", resp_log[1], 5);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
